// File: rtl/ahb_apb3_bridge.sv
// rtl/ahb_apb3_bridge.sv - AHB-Lite slave to APB3/APB4 master bridge with decode, strobes, errors and timeout
module ahb_apb3_bridge #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                SLAVES      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                REGION_BITS = 24,
    parameter int                TIMEOUT     = 0
) (
    input  logic                     Hclk,
    input  logic                     Hresetn,
    input  logic [1:0]               Htrans,
    input  logic [2:0]               Hsize,
    input  logic                     Hreadyin,
    input  logic                     Hwrite,
    input  logic [ADDR_W-1:0]        Haddr,
    input  logic [DATA_W-1:0]        Hwdata,
    output logic [DATA_W-1:0]        Hrdata,
    output logic [1:0]               Hresp,
    output logic                     Hreadyout,
    output logic [SLAVES-1:0]        Pselx,
    output logic                     Penable,
    output logic                     Pwrite,
    output logic [ADDR_W-1:0]        Paddr,
    output logic [DATA_W-1:0]        Pwdata,
    output logic [DATA_W/8-1:0]      Pstrb,
    input  logic [SLAVES*DATA_W-1:0] Prdata,
    input  logic [SLAVES-1:0]        Pready,
    input  logic [SLAVES-1:0]        Pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LOG2B  = $clog2(STRB_W);
    localparam int SEL_W  = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam logic [31:0] TO_LAST   = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WWAIT,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic                r_hready;
    logic [1:0]          r_hresp;
    logic [DATA_W-1:0]   r_hrdata;
    logic [SLAVES-1:0]   r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic [31:0]         r_tcnt;

    // Address decode: offset from the window base selects a region; low addresses and oversize transfers miss
    logic [ADDR_W-1:0]   w_offset;
    logic [ADDR_W-1:0]   w_region;
    logic                w_hit;
    logic [SEL_W-1:0]    w_dec_sel;
    logic                w_accept;
    logic [LOG2B-1:0]    w_lane;
    logic [STRB_W:0]     w_size_mask;
    logic [STRB_W-1:0]   w_strb;
    logic                w_pready_sel;
    logic                w_pslverr_sel;
    logic [DATA_W-1:0]   w_prdata_sel;
    logic                w_timeout;
    logic                w_unused;

    assign w_offset      = Haddr - BASE_ADDR;
    assign w_region      = w_offset >> REGION_BITS;
    assign w_hit         = (Haddr >= BASE_ADDR) && (w_region < ADDR_W'(SLAVES)) && (Hsize <= 3'(LOG2B));
    assign w_dec_sel     = w_region[SEL_W-1:0];
    assign w_accept      = Hreadyin && Htrans[1] && ((r_state == S_IDLE) || (r_state == S_ERR2));
    assign w_lane        = Haddr[LOG2B-1:0];
    // Mask one bit wider than the lanes so a full-width transfer does not overflow before the subtract
    assign w_size_mask   = ((STRB_W+1)'(1) << (8'd1 << Hsize)) - (STRB_W+1)'(1);
    assign w_strb        = w_size_mask[STRB_W-1:0] << w_lane;
    assign w_pready_sel  = Pready[r_sel];
    assign w_pslverr_sel = Pslverr[r_sel];
    assign w_prdata_sel  = Prdata[r_sel*DATA_W +: DATA_W];
    assign w_timeout     = (TIMEOUT > 0) && (r_tcnt == TO_LAST);
    assign w_unused      = &{1'b0, Htrans[0]};

    // Bridge FSM; every output is set on the transition into the state that owns it
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_hready  <= 1'b1;
            r_hresp   <= RESP_OKAY;
            r_hrdata  <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_tcnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ERR2: begin
                    r_state  <= S_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= RESP_OKAY;
                    if (w_accept) begin
                        r_hready <= 1'b0;
                        if (!w_hit) begin
                            r_state <= S_ERR1;
                            r_hresp <= RESP_ERR;
                        end else begin
                            r_sel    <= w_dec_sel;
                            r_paddr  <= Haddr;
                            r_pwrite <= Hwrite;
                            r_pstrb  <= Hwrite ? w_strb : '0;
                            if (Hwrite) begin
                                r_state <= S_WWAIT;
                            end else begin
                                r_state <= S_SETUP;
                                r_psel  <= SLAVES'(1) << w_dec_sel;
                                r_tcnt  <= '0;
                            end
                        end
                    end
                end
                S_WWAIT: begin
                    r_pwdata <= Hwdata;
                    r_psel   <= SLAVES'(1) << r_sel;
                    r_tcnt   <= '0;
                    r_state  <= S_SETUP;
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_pready_sel) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        if (w_pslverr_sel) begin
                            r_state <= S_ERR1;
                            r_hresp <= RESP_ERR;
                        end else begin
                            r_state  <= S_IDLE;
                            r_hready <= 1'b1;
                            if (!r_pwrite) begin
                                r_hrdata <= w_prdata_sel;
                            end
                        end
                    end else if (w_timeout) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_state   <= S_ERR1;
                        r_hresp   <= RESP_ERR;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
                end
                S_ERR1: begin
                    r_hready <= 1'b1;
                    r_hresp  <= RESP_ERR;
                    r_state  <= S_ERR2;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Hrdata    = r_hrdata;
    assign Hresp     = r_hresp;
    assign Hreadyout = r_hready;
    assign Pselx     = r_psel;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;
    assign Pstrb     = r_pstrb;

endmodule

// File: tb/tb_ahb_apb3_bridge.sv
// tb/tb_ahb_apb3_bridge.sv - scoreboard bench for ahb_apb3_bridge
module tb_ahb_apb3_bridge;

    logic         Hclk = 1'b0;
    logic         Hresetn;
    logic [1:0]   Htrans;
    logic [2:0]   Hsize;
    logic         Hreadyin;
    logic         Hwrite;
    logic [31:0]  Haddr;
    logic [31:0]  Hwdata;
    logic [31:0]  Hrdata;
    logic [1:0]   Hresp;
    logic         Hreadyout;
    logic [3:0]   Pselx;
    logic         Penable;
    logic         Pwrite;
    logic [31:0]  Paddr;
    logic [31:0]  Pwdata;
    logic [3:0]   Pstrb;
    logic [127:0] Prdata;
    logic [3:0]   Pready;
    logic [3:0]   Pslverr;

    ahb_apb3_bridge #(
        .ADDR_W(32), .DATA_W(32), .SLAVES(4), .BASE_ADDR(32'h8000_0000),
        .REGION_BITS(24), .TIMEOUT(8)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Htrans(Htrans), .Hsize(Hsize),
        .Hreadyin(Hreadyin), .Hwrite(Hwrite), .Haddr(Haddr), .Hwdata(Hwdata),
        .Hrdata(Hrdata), .Hresp(Hresp), .Hreadyout(Hreadyout),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
        .Pwdata(Pwdata), .Pstrb(Pstrb), .Prdata(Prdata), .Pready(Pready),
        .Pslverr(Pslverr)
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        logic [1:0]  resp;
        int          low;
        logic        rd;
        logic [31:0] rdata;
    } ahb_exp_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          acc;
    } apb_exp_t;

    ahb_exp_t ahb_q[$];
    apb_exp_t apb_q[$];
    int       setup_cyc[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          slv_wait = 0;
    logic        slv_err  = 1'b0;
    int          slv_acc  = 0;
    logic [31:0] slv_data [4];

    int          low_n = 0;
    logic [1:0]  last_low_resp = 2'b00;
    logic        apb_busy = 1'b0;
    int          apb_acc = 0;
    logic [3:0]  c_sel;
    logic [31:0] c_addr;
    logic        c_wr;
    logic [3:0]  c_strb;
    logic [31:0] c_wdata;
    ahb_exp_t    ae;
    apb_exp_t    pe;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp_ahb(input logic [1:0] resp, input int low, input logic rd, input logic [31:0] rdata);
        ahb_exp_t e;
        e.resp = resp; e.low = low; e.rd = rd; e.rdata = rdata;
        ahb_q.push_back(e);
    endtask

    task automatic exp_apb(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                           input logic [3:0] strb, input logic [31:0] wdata, input int acc);
        apb_exp_t e;
        e.sel = sel; e.addr = addr; e.wr = wr; e.strb = strb; e.wdata = wdata; e.acc = acc;
        apb_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size, input logic [31:0] wdata);
        int n = 0;
        while (Hreadyout !== 1'b1 && n < 200) begin
            @(posedge Hclk); #1;
            n++;
        end
        if (n >= 200) check("issue_wait", 0, 1);
        Htrans = 2'b10; Haddr = addr; Hwrite = wr; Hsize = size;
        @(posedge Hclk); #1;
        Htrans = 2'b00; Hwdata = wdata;
    endtask

    task automatic drain();
        int n = 0;
        while ((ahb_q.size() != 0 || apb_q.size() != 0 || Hreadyout !== 1'b1) && n < 300) begin
            @(posedge Hclk); #1;
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_ctl"}, {Hreadyout, Hresp, Pselx, Penable, Pwrite, Pstrb}, 13'b1_00_0000_0_0_0000);
        check({tag, "_paddr"}, Paddr, 0);
        check({tag, "_pwdata"}, Pwdata, 0);
        check({tag, "_hrdata"}, Hrdata, 0);
    endtask

    always @(posedge Hclk) cyc <= cyc + 1;

    // APB slave model: unselected slaves drive the opposite of what the selected one drives
    initial begin
        Pready = 4'b0000;
        Pslverr = 4'b0000;
        forever begin
            @(posedge Hclk); #1;
            if (Penable && Pselx != 4'b0000) begin
                Pready  = (slv_acc >= slv_wait) ? Pselx : ~Pselx;
                Pslverr = slv_err ? Pselx : ~Pselx;
                slv_acc++;
            end else begin
                slv_acc = 0;
                Pready  = ~Pselx;
                Pslverr = ~Pselx;
            end
        end
    end

    // Monitors: AHB responses and APB transfers, popped from the scoreboard queues
    initial begin
        forever begin
            @(negedge Hclk);
            if (Hresetn !== 1'b1) begin
                low_n = 0;
                apb_busy = 1'b0;
            end else begin
                if (!Hreadyout) begin
                    low_n++;
                    last_low_resp = Hresp;
                end else if (low_n > 0) begin
                    if (ahb_q.size() == 0) begin
                        check("ahb_unexpected", 1, 0);
                    end else begin
                        ae = ahb_q.pop_front();
                        check("ahb_low_cycles", low_n, ae.low);
                        check("ahb_resp_lastlow", last_low_resp, ae.resp);
                        check("ahb_resp", Hresp, ae.resp);
                        if (ae.rd) check("ahb_rdata", Hrdata, ae.rdata);
                    end
                    low_n = 0;
                end
                if (Pselx != 4'b0000) begin
                    if (!apb_busy) begin
                        apb_busy = 1'b1;
                        apb_acc = 0;
                    end
                    if (!Penable) begin
                        setup_cyc.push_back(cyc);
                    end else begin
                        apb_acc++;
                        c_sel = Pselx; c_addr = Paddr; c_wr = Pwrite; c_strb = Pstrb; c_wdata = Pwdata;
                    end
                end else if (apb_busy) begin
                    apb_busy = 1'b0;
                    if (apb_q.size() == 0) begin
                        check("apb_unexpected", 1, 0);
                    end else begin
                        pe = apb_q.pop_front();
                        check("apb_sel", c_sel, pe.sel);
                        check("apb_addr", c_addr, pe.addr);
                        check("apb_write", c_wr, pe.wr);
                        check("apb_strb", c_strb, pe.strb);
                        if (pe.wr) check("apb_wdata", c_wdata, pe.wdata);
                        check("apb_access_cycles", apb_acc, pe.acc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int gap;
        slv_data[0] = 32'hA0A0_0000;
        slv_data[1] = 32'h5A5A_1111;
        slv_data[2] = 32'h1234_5678;
        slv_data[3] = 32'hC3C3_3C3C;
        for (int i = 0; i < 4; i++) Prdata[i*32 +: 32] = slv_data[i];
        Hresetn = 1'b0; Htrans = 2'b00; Hsize = 3'd0; Hreadyin = 1'b1;
        Hwrite = 1'b0; Haddr = 32'h0; Hwdata = 32'h0;
        repeat (3) @(posedge Hclk);
        #1;
        reset_check("reset");
        Hresetn = 1'b1;
        @(posedge Hclk); #1;

        // Hreadyin low and BUSY transfers must not be accepted
        Hreadyin = 1'b0; Htrans = 2'b10; Haddr = 32'h8000_0000; Hsize = 3'd2;
        repeat (2) @(posedge Hclk);
        #1;
        check("no_accept_hreadyin", {Hreadyout, Pselx}, 5'b1_0000);
        Hreadyin = 1'b1; Htrans = 2'b01;
        repeat (2) @(posedge Hclk);
        #1;
        check("no_accept_busy", {Hreadyout, Pselx}, 5'b1_0000);
        Htrans = 2'b00;

        // Word write, zero wait
        exp_apb(4'b0001, 32'h8000_0010, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1);
        exp_ahb(2'b00, 3, 1'b0, 32'h0);
        issue(32'h8000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF);
        drain();

        // Halfword write to upper lanes
        exp_apb(4'b0001, 32'h8000_0002, 1'b1, 4'b1100, 32'h5555_0000, 1);
        exp_ahb(2'b00, 3, 1'b0, 32'h0);
        issue(32'h8000_0002, 1'b1, 3'd1, 32'h5555_0000);
        drain();

        // Read with two wait states
        slv_wait = 2;
        exp_apb(4'b0100, 32'h8200_0004, 1'b0, 4'b0000, 32'h0, 3);
        exp_ahb(2'b00, 4, 1'b1, 32'h1234_5678);
        issue(32'h8200_0004, 1'b0, 3'd2, 32'h0);
        drain();
        slv_wait = 0;

        // Byte write answered with a slave error
        slv_err = 1'b1;
        exp_apb(4'b0010, 32'h8100_0003, 1'b1, 4'b1000, 32'hAB00_0000, 1);
        exp_ahb(2'b01, 4, 1'b0, 32'h0);
        issue(32'h8100_0003, 1'b1, 3'd0, 32'hAB00_0000);
        drain();
        slv_err = 1'b0;
        check("okay_after_err", {Hreadyout, Hresp}, 3'b100);
        check("hrdata_hold_err", Hrdata, 32'h1234_5678);

        // Decode misses: past last slave, below base, oversize
        exp_ahb(2'b01, 1, 1'b0, 32'h0);
        exp_ahb(2'b01, 1, 1'b0, 32'h0);
        exp_ahb(2'b01, 1, 1'b0, 32'h0);
        issue(32'h8400_0000, 1'b0, 3'd2, 32'h0);
        issue(32'h7FFF_FFFC, 1'b1, 3'd2, 32'h0BAD_0BAD);
        issue(32'h8000_0000, 1'b0, 3'd3, 32'h0);
        drain();
        check("hrdata_hold_miss", Hrdata, 32'h1234_5678);

        // Timeout with Pready held low
        slv_wait = 100;
        exp_apb(4'b1000, 32'h8300_0000, 1'b0, 4'b0000, 32'h0, 8);
        exp_ahb(2'b01, 10, 1'b0, 32'h0);
        issue(32'h8300_0000, 1'b0, 3'd2, 32'h0);
        drain();
        slv_wait = 0;

        // Back-to-back reads to slaves 0 and 3
        setup_cyc.delete();
        exp_apb(4'b0001, 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 1);
        exp_ahb(2'b00, 2, 1'b1, 32'hA0A0_0000);
        exp_apb(4'b1000, 32'h8300_0008, 1'b0, 4'b0000, 32'h0, 1);
        exp_ahb(2'b00, 2, 1'b1, 32'hC3C3_3C3C);
        issue(32'h8000_0000, 1'b0, 3'd2, 32'h0);
        issue(32'h8300_0008, 1'b0, 3'd2, 32'h0);
        drain();
        check("b2b_setups", setup_cyc.size(), 2);
        gap = (setup_cyc.size() == 2) ? (setup_cyc[1] - setup_cyc[0]) : -1;
        check("b2b_setup_gap", gap, 3);

        // Reset during ACCESS: no response expected
        slv_wait = 5;
        issue(32'h8100_0000, 1'b0, 3'd2, 32'h0);
        n = 0;
        while (Penable !== 1'b1 && n < 20) begin
            @(posedge Hclk); #1;
            n++;
        end
        check("rst_reached_access", Penable, 1'b1);
        Hresetn = 1'b0;
        @(posedge Hclk); #1;
        reset_check("rst_mid");
        Hresetn = 1'b1;
        slv_wait = 0;
        @(posedge Hclk); #1;

        // Normal read after reset
        exp_apb(4'b0010, 32'h8100_0010, 1'b0, 4'b0000, 32'h0, 1);
        exp_ahb(2'b00, 2, 1'b1, 32'h5A5A_1111);
        issue(32'h8100_0010, 1'b0, 3'd2, 32'h0);
        drain();

        check("ahb_q_empty", ahb_q.size(), 0);
        check("apb_q_empty", apb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
